// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared core widths and writeback request type
// Contents: WORD_WIDTH, REG_ADDR_WIDTH, wb_req_t {valid, addr, data}, ptr_width().
package wb_port_arbiter_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0]     data;
    } wb_req_t;

    // Pointer width that stays at least one bit for a single-entry FIFO.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// rtl/wb_pend_fifo.sv - pending writeback FIFO with per-entry kill-by-address
// Ports: clk/rst (sync, active-high); push/push_req/push_kill enqueue;
//        pop drops the head; kill_en/kill_addr mark matching entries dead;
//        full, head, head_killed report state.
//        With WB_ARB_FWD_EN: fwd_addr lookup -> fwd_hit/fwd_data (youngest live match).
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_req_t                   push_req,
    input  logic                      push_kill,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [REG_ADDR_WIDTH-1:0] kill_addr,
    output logic                      full,
    output wb_req_t                   head,
    output logic                      head_killed
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_hit,
    output logic [WORD_WIDTH-1:0]     fwd_data
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t          mem    [DEPTH];
    logic             killed [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]    <= '0;
                killed[i] <= 1'b0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].valid && mem[i].addr == kill_addr)
                    killed[i] <= 1'b1;
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                killed[rd_ptr]    <= 1'b0;
                rd_ptr            <= next_ptr(rd_ptr);
            end
            // push never targets the head slot: it is only allowed when not full
            if (push) begin
                mem[wr_ptr]    <= '{valid: 1'b1, addr: push_req.addr, data: push_req.data};
                killed[wr_ptr] <= push_kill || (kill_en && kill_addr == push_req.addr);
                wr_ptr         <= next_ptr(wr_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full        = (count == CW'(DEPTH));
    assign head        = mem[rd_ptr];
    assign head_killed = killed[rd_ptr];

`ifdef WB_ARB_FWD_EN
    // Walk oldest to youngest so the youngest live match wins.
    always_comb begin
        int j;
        j        = 0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = int'(rd_ptr) + k;
            if (j >= DEPTH)
                j = j - DEPTH;
            if (fwd_addr != '0 && mem[j].valid && !killed[j] && mem[j].addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[j].data;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter (pipeline vs secondary)
// Ports: gclk, rst (sync, active-high); p_* pipeline writeback (never back-pressured);
//        s_valid/s_ready/s_addr/s_data secondary request; stall_req asks the pipeline
//        to hold p_valid low; RegWrite* drive the register file.
//        Optional macro WB_ARB_FWD_EN adds fwd_addr/fwd_hit/fwd_data lookup ports.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      gclk,
    input  logic                      rst,
    input  logic                      p_valid,
    input  logic [REG_ADDR_WIDTH-1:0] p_addr,
    input  logic [WORD_WIDTH-1:0]     p_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [REG_ADDR_WIDTH-1:0] s_addr,
    input  logic [WORD_WIDTH-1:0]     s_data,
    output logic                      stall_req,
    output logic                      RegWriteEnable,
    output logic [REG_ADDR_WIDTH-1:0] RegWriteAddr,
    output logic [WORD_WIDTH-1:0]     RegWriteData
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_hit,
    output logic [WORD_WIDTH-1:0]     fwd_data
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          full;
    wb_req_t       head;
    logic          head_killed;
    wb_req_t       push_req;
    logic          push;
    logic          pop;
    logic          head_dead;
    logic          sec_write;
    logic          blocked;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    assign s_ready  = !rst && !full;
    assign push     = s_valid && s_ready;
    assign push_req = '{valid: 1'b1, addr: s_addr, data: s_data};

    // A head hit by this cycle's pipeline write is already dead; drop it now.
    assign head_dead = head_killed || (p_valid && head.addr == p_addr);
    assign pop       = !rst && head.valid && (head_dead || !p_valid);
    assign sec_write = head.valid && !head_dead && !p_valid;
    assign blocked   = head.valid && !head_dead && p_valid;

    wb_pend_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (gclk),
        .rst         (rst),
        .push        (push),
        .push_req    (push_req),
        .push_kill   (s_addr == '0),
        .pop         (pop),
        .kill_en     (p_valid),
        .kill_addr   (p_addr),
        .full        (full),
        .head        (head),
        .head_killed (head_killed)
`ifdef WB_ARB_FWD_EN
        ,
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    always_comb begin
        RegWriteEnable = 1'b0;
        RegWriteAddr   = p_addr;
        RegWriteData   = p_data;
        if (!rst) begin
            if (p_valid) begin
                RegWriteEnable = (p_addr != '0);
            end else if (sec_write) begin
                RegWriteEnable = 1'b1;
                RegWriteAddr   = head.addr;
                RegWriteData   = head.data;
            end
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (pop)
            starve_next = '0;
        else if (blocked && starve_cnt != SW'(STARVE_LIMIT))
            starve_next = starve_cnt + 1'b1;
    end

    // stall_req is registered from the next counter value so it tracks
    // "counter == STARVE_LIMIT" cycle for cycle.
    always_ff @(posedge gclk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == SW'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic                      gclk = 1'b0;
    logic                      rst = 1'b1;
    logic                      p_valid = 1'b0;
    logic [REG_ADDR_WIDTH-1:0] p_addr = '0;
    logic [WORD_WIDTH-1:0]     p_data = '0;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [REG_ADDR_WIDTH-1:0] s_addr = '0;
    logic [WORD_WIDTH-1:0]     s_data = '0;
    logic                      stall_req;
    logic                      RegWriteEnable;
    logic [REG_ADDR_WIDTH-1:0] RegWriteAddr;
    logic [WORD_WIDTH-1:0]     RegWriteData;
`ifdef WB_ARB_FWD_EN
    logic [REG_ADDR_WIDTH-1:0] fwd_addr = '0;
    logic                      fwd_hit;
    logic [WORD_WIDTH-1:0]     fwd_data;
    logic                      obs_hit;
    logic [WORD_WIDTH-1:0]     obs_fd;
`endif

    always #5 gclk = ~gclk;

    wb_port_arbiter #(
        .FIFO_DEPTH     (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .gclk           (gclk),
        .rst            (rst),
        .p_valid        (p_valid),
        .p_addr         (p_addr),
        .p_data         (p_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_addr         (s_addr),
        .s_data         (s_data),
        .stall_req      (stall_req),
        .RegWriteEnable (RegWriteEnable),
        .RegWriteAddr   (RegWriteAddr),
        .RegWriteData   (RegWriteData)
`ifdef WB_ARB_FWD_EN
        ,
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: ordered list of pending writes plus a blocked-cycle tally.
    typedef struct {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0]     data;
        bit                        killed;
    } ent_t;
    ent_t q[$];
    int   starve = 0;

    logic [WORD_WIDTH-1:0]     rf_obs [32];
    logic                      obs_we;
    logic                      obs_ready;
    logic                      obs_stall;
    logic [REG_ADDR_WIDTH-1:0] obs_addr;
    logic [WORD_WIDTH-1:0]     obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic pv, input logic [REG_ADDR_WIDTH-1:0] pa,
                        input logic [WORD_WIDTH-1:0] pd, input logic sv,
                        input logic [REG_ADDR_WIDTH-1:0] sa, input logic [WORD_WIDTH-1:0] sd);
        bit                        e_ready;
        bit                        e_stall;
        bit                        e_we;
        logic [REG_ADDR_WIDTH-1:0] e_addr;
        logic [WORD_WIDTH-1:0]     e_data;
        rst = r; p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        #3;
        e_stall = (starve == LIMIT);
`ifdef WB_ARB_FWD_EN
        begin
            bit                    e_hit;
            logic [WORD_WIDTH-1:0] e_fd;
            e_hit = 1'b0;
            e_fd  = '0;
            if (fwd_addr != '0)
                foreach (q[i])
                    if (q[i].addr == fwd_addr && !q[i].killed) begin
                        e_hit = 1'b1;
                        e_fd  = q[i].data;
                    end
            chk("fwd_hit", fwd_hit, e_hit);
            if (e_hit)
                chk("fwd_data", fwd_data, e_fd);
            obs_hit = fwd_hit;
            obs_fd  = fwd_data;
        end
`endif
        e_addr = pa;
        e_data = pd;
        if (r) begin
            e_ready = 1'b0;
            e_we    = 1'b0;
            q.delete();
            starve  = 0;
        end else begin
            e_ready = (q.size() < DEPTH);
            if (pv)
                foreach (q[i])
                    if (q[i].addr == pa)
                        q[i].killed = 1'b1;
            e_we = pv && (pa != '0);
            if (q.size() > 0) begin
                if (q[0].killed) begin
                    void'(q.pop_front());
                    starve = 0;
                end else if (!pv) begin
                    e_we   = 1'b1;
                    e_addr = q[0].addr;
                    e_data = q[0].data;
                    void'(q.pop_front());
                    starve = 0;
                end else if (starve < LIMIT) begin
                    starve++;
                end
            end
            if (sv && e_ready)
                q.push_back('{addr: sa, data: sd, killed: (sa == '0) || (pv && pa == sa)});
        end
        chk("we", RegWriteEnable, e_we);
        if (e_we) begin
            chk("waddr", RegWriteAddr, e_addr);
            chk("wdata", RegWriteData, e_data);
        end
        chk("s_ready", s_ready, e_ready);
        chk("stall_req", stall_req, e_stall);
        chk("pv_while_stall", p_valid && stall_req, 1'b0);
        obs_we    = RegWriteEnable;
        obs_addr  = RegWriteAddr;
        obs_data  = RegWriteData;
        obs_ready = s_ready;
        obs_stall = stall_req;
        if (obs_we === 1'b1)
            rf_obs[obs_addr] = obs_data;
        @(posedge gclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf_obs[i] = '0;
        repeat (2) @(posedge gclk);
        #1;

        // reset holds the write port off even with a pipeline request
        step(1, 1, 5'd7, 32'h77, 1, 5'd5, 32'h1);
        chk("rst_we", obs_we, 1'b0);
        chk("rst_ready", obs_ready, 1'b0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("ready_after_rst", obs_ready, 1'b1);

        // pipeline priority
        step(0, 1, 5'd3, 32'h1234, 1, 5'd5, 32'hBEEF);
        chk("prio_p_we", obs_we, 1'b1);
        chk("prio_p_addr", obs_addr, 5'd3);
        chk("prio_p_data", obs_data, 32'h1234);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("prio_s_we", obs_we, 1'b1);
        chk("prio_s_addr", obs_addr, 5'd5);
        chk("prio_s_data", obs_data, 32'hBEEF);

        // full FIFO
        step(0, 1, 5'd1, 32'h11, 1, 5'd6, 32'h66);
        step(0, 1, 5'd1, 32'h11, 1, 5'd7, 32'h77);
        step(0, 1, 5'd1, 32'h11, 1, 5'd8, 32'h88);
        chk("full_ready", obs_ready, 1'b0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("ready_at_pop", obs_ready, 1'b0);
        chk("full_first_addr", obs_addr, 5'd6);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("ready_after_pop", obs_ready, 1'b1);
        chk("full_second_addr", obs_addr, 5'd7);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("third_not_taken", obs_we, 1'b0);

        // kill by pipeline write
        step(0, 0, 5'd0, 32'h0, 1, 5'd2, 32'hAAAA);
        step(0, 1, 5'd2, 32'h5555, 0, 5'd0, 32'h0);
        chk("kill_p_data", obs_data, 32'h5555);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("kill_no_write", obs_we, 1'b0);
        chk("r2_final", rf_obs[2], 32'h5555);

        // starvation
        step(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99);
        for (int i = 0; i < LIMIT; i++)
            step(0, 1, 5'd10, 32'h10, 0, 5'd0, 32'h0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("starve_stall", obs_stall, 1'b1);
        chk("starve_drain_addr", obs_addr, 5'd9);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("starve_release", obs_stall, 1'b0);

        // r0 writes from both sources
        step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        chk("r0_p_we", obs_we, 1'b0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("r0_s_we", obs_we, 1'b0);

        // reset with two entries pending
        step(0, 1, 5'd1, 32'h1, 1, 5'd11, 32'hB);
        step(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("post_rst_we", obs_we, 1'b0);
        chk("post_rst_ready", obs_ready, 1'b1);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("post_rst_we2", obs_we, 1'b0);

`ifdef WB_ARB_FWD_EN
        fwd_addr = 5'd4;
        step(0, 1, 5'd1, 32'h1, 1, 5'd4, 32'h0001);
        step(0, 1, 5'd1, 32'h1, 1, 5'd4, 32'h0002);
        step(0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0);
        chk("fwd_young_hit", obs_hit, 1'b1);
        chk("fwd_young_data", obs_fd, 32'h0002);
        fwd_addr = 5'd0;
        step(0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0);
        chk("fwd_r0_hit", obs_hit, 1'b0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
`endif

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic r;
            logic pv;
            r  = ($urandom_range(0, 59) == 0);
            pv = (starve == LIMIT) ? 1'b0 : ($urandom_range(0, 2) != 0);
`ifdef WB_ARB_FWD_EN
            fwd_addr = 5'($urandom_range(0, 7));
`endif
            step(r, pv, 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- FIFO_DEPTH, default 2: pending-entry count for the secondary requester.
- STARVE_LIMIT, default 4: blocked-cycle count before a stall is requested.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- gclk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- p_valid  in  1  pipeline writeback request; cannot be back-pressured.
- p_addr  in  REG_ADDR_WIDTH  pipeline destination register.
- p_data  in  WORD_WIDTH  pipeline write data.
- s_valid  in  1  secondary (multi-cycle unit) request.
- s_ready  out  1  secondary accept.
- s_addr  in  REG_ADDR_WIDTH  secondary destination register.
- s_data  in  WORD_WIDTH  secondary write data.
- stall_req  out  1  pipeline must hold p_valid low.
- RegWriteEnable  out  1  register file write enable.
- RegWriteAddr  out  REG_ADDR_WIDTH  register file write address.
- RegWriteData  out  WORD_WIDTH  register file write data.

Function
REQ-003 Pipeline requests SHALL have absolute priority and reach the write port combinationally in the same cycle (zero latency).
REQ-004 A secondary request SHALL be accepted on s_valid&&s_ready and enqueued into the FIFO; s_ready SHALL be 1 iff the registered count is below FIFO_DEPTH, with no same-cycle pass-through when full.
REQ-005 The FIFO head SHALL drive the write port in any cycle with p_valid=0 and a valid head, then pop; minimum accept-to-write latency is 1 cycle.
REQ-006 Writes to address 0 SHALL be dropped: a pipeline write to r0 never asserts RegWriteEnable, and a secondary write to r0 is accepted but enqueued as killed.
REQ-007 A pipeline write to address A SHALL kill every valid FIFO entry with address A, including an entry enqueued in the same cycle.
REQ-008 A killed head SHALL pop in any cycle without asserting RegWriteEnable, including cycles with p_valid=1.
REQ-009 A starvation counter SHALL increment each cycle a valid, unkilled head is blocked by p_valid, SHALL saturate at STARVE_LIMIT, and SHALL clear when the head pops.
REQ-010 stall_req SHALL be a registered output, asserted while the counter equals STARVE_LIMIT.
REQ-011 The pipeline SHALL keep p_valid=0 whenever stall_req=1; the head therefore drains in that cycle and stall_req deasserts the next cycle.
REQ-012 Simultaneous enqueue and pop SHALL keep the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-013 While rst=1 the block SHALL:
- clear all FIFO entries, the count and the starvation counter;
- drive stall_req=0 and s_ready=0;
- drive RegWriteEnable=0 regardless of p_valid.
REQ-014 s_ready SHALL rise in the first cycle after rst falls.
REQ-015 A reset asserted mid-operation SHALL discard all pending entries without writing them.

Configuration
REQ-016 When WB_ARB_FWD_EN is defined, the block SHALL add these ports:
- fwd_addr  in  REG_ADDR_WIDTH  forwarding lookup address.
- fwd_hit  out  1  a valid, unkilled FIFO entry matches fwd_addr.
- fwd_data  out  WORD_WIDTH  data of the youngest matching entry.
REQ-017 The forwarding lookup SHALL be combinational, and SHALL report fwd_hit=0 for address 0.
REQ-018 When WB_ARB_FWD_EN is undefined, these ports and their logic SHALL be absent.

Structure
REQ-019 WORD_WIDTH, REG_ADDR_WIDTH and a wb_req_t struct {valid, addr, data} SHALL live in the shared core package.
REQ-020 The FIFO SHALL be a sub-module named wb_pend_fifo, supporting per-entry kill-by-address and head pop.
REQ-021 The arbitration, kill and starvation logic SHALL reside in wb_port_arbiter.

Verification
REQ-022 Scenario, pipeline priority: p_valid=1 with addr 3 and data 0x1234, while s_valid=1 with addr 5 and data 0xBEEF.
- Same cycle: the port writes r3=0x1234.
- Next cycle, with p_valid=0: the port writes r5=0xBEEF.
REQ-023 Scenario, full FIFO: fill both entries while p_valid=1 is held. Required: s_ready=0; a third s_valid is not accepted; s_ready returns to 1 the cycle after the first pop.
REQ-024 Scenario, kill: enqueue s addr 2 with data 0xAAAA, then p writes r2=0x5555.
- The stale entry never writes r2.
- The final r2 value is 0x5555.
- The killed entry pops during a p_valid=1 cycle.
REQ-025 Scenario, starvation: one FIFO entry is pending and p_valid=1 is held continuously.
- stall_req rises after 4 blocked cycles.
- The bench drops p_valid; the entry writes; stall_req falls one cycle later.
- An assertion flags any cycle with p_valid=1 while stall_req=1.
REQ-026 Scenario, r0 and reset: an r0 write from either source yields RegWriteEnable=0. Asserting rst with 2 entries pending produces no writes afterward, and s_ready=1 one cycle after release.
REQ-027 Scenario, forwarding (WB_ARB_FWD_EN only): entries r4=0x0001 (older) and r4=0x0002 (younger) are pending, and fwd_addr=4. Required: fwd_hit=1, fwd_data=0x0002.
